// File: rtl/inst_id_pkg.sv
// Shared types and elaboration-time helpers for the instance-identity tree.
// Leaf count and index width are derived here so every level agrees on them.
package inst_id_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } scan_state_e;

    function automatic int leaf_count(input int levels, input int fanout);
        int n;
        n = 1;
        for (int i = 0; i < levels; i++) begin
            n = n * fanout;
        end
        return n;
    endfunction

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/inst_id_node.sv
// One node of the identity tree. A node either recurses into FANOUT children
// or, at the bottom, holds a single leaf tag register tied to its leaf index.
module inst_id_node
    import inst_id_pkg::*;
#(
    parameter int LEVEL    = 1,
    parameter int FANOUT   = 2,
    parameter int TAG_W    = 8,
    parameter int TAG_BASE = 1,
    parameter int IDX_W    = 1,
    parameter int BASE_IDX = 0,
    localparam int SUB_N   = leaf_count(LEVEL, FANOUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_addr,
    input  logic [TAG_W-1:0]       wr_tag,
    output logic [SUB_N*TAG_W-1:0] tags
);

    if (LEVEL == 0) begin : g_leaf
        localparam logic [IDX_W-1:0] IDX     = IDX_W'(BASE_IDX);
        localparam logic [TAG_W-1:0] RST_TAG = TAG_W'(TAG_BASE + BASE_IDX);

        logic [TAG_W-1:0] tag_q;

        // NOTE: non-blocking assignments for all clocked state, so every
        // register samples pre-edge values regardless of evaluation order.
        // NOTE: these tag registers are reset on purpose; a leaf's default
        // tag is part of its visible identity, unlike ordinary RAM contents.
        always_ff @(posedge clk) begin
            if (rst) begin
                tag_q <= RST_TAG;
            end else if (wr_en && wr_addr == IDX) begin
                tag_q <= wr_tag;
            end
        end

        assign tags = tag_q;
    end else begin : g_branch
        localparam int CHILD_N = leaf_count(LEVEL - 1, FANOUT);

        for (genvar b = 0; b < FANOUT; b++) begin : g_child
            inst_id_node #(
                .LEVEL   (LEVEL - 1),
                .FANOUT  (FANOUT),
                .TAG_W   (TAG_W),
                .TAG_BASE(TAG_BASE),
                .IDX_W   (IDX_W),
                .BASE_IDX(BASE_IDX + b * CHILD_N)
            ) u_node (
                .clk    (clk),
                .rst    (rst),
                .wr_en  (wr_en),
                .wr_addr(wr_addr),
                .wr_tag (wr_tag),
                .tags   (tags[b*CHILD_N*TAG_W +: CHILD_N*TAG_W])
            );
        end
    end

endmodule

// File: rtl/inst_id_tree_scan.sv
// Instance-identity tree with a scan sequencer that streams one registered
// record (index, identity, tag) per leaf over a valid/ready interface.
module inst_id_tree_scan
    import inst_id_pkg::*;
#(
    parameter int LEVELS   = 4,
    parameter int FANOUT   = 2,
    parameter int ID_W     = 32,
    parameter int TAG_W    = 8,
    parameter int TAG_BASE = 1,
    localparam int NLEAF   = leaf_count(LEVELS, FANOUT),
    localparam int IDX_W   = (clog2(NLEAF) < 1) ? 1 : clog2(NLEAF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [ID_W-1:0]  root_id,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [TAG_W-1:0] wr_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [ID_W-1:0]  out_id,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLEAF - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [ID_W-1:0]  ID_SCALE = ID_W'(NLEAF);

    scan_state_e            state_q;
    scan_state_e            state_d;
    logic                   dir_q;
    logic [ID_W-1:0]        root_q;
    logic [NLEAF*TAG_W-1:0] tag_flat;
    logic                   load;
    logic [IDX_W-1:0]       load_idx;
    logic [ID_W-1:0]        load_root;
    logic [TAG_W-1:0]       load_tag;
    logic [IDX_W-1:0]       end_idx;

    inst_id_node #(
        .LEVEL   (LEVELS),
        .FANOUT  (FANOUT),
        .TAG_W   (TAG_W),
        .TAG_BASE(TAG_BASE),
        .IDX_W   (IDX_W),
        .BASE_IDX(0)
    ) u_tree (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_tag (wr_tag),
        .tags   (tag_flat)
    );

    assign end_idx   = dir_q ? '0 : LAST_IDX;
    assign out_valid = (state_q == SCAN);
    assign busy      = (state_q == SCAN);
    assign done      = (state_q == DONE);
    assign out_last  = (state_q == SCAN) && (out_idx == end_idx);

    // A write landing on the same edge a record is loaded is forwarded, so a
    // leaf that has not been presented yet always shows its newest tag.
    assign load_tag = (wr_en && wr_addr == load_idx) ? wr_tag
                                                     : tag_flat[int'(load_idx)*TAG_W +: TAG_W];

    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        load_idx  = out_idx;
        load_root = root_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SCAN;
                    load      = 1'b1;
                    load_root = root_id;
                    load_idx  = dir ? LAST_IDX : '0;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    if (out_last) begin
                        state_d = DONE;
                    end else begin
                        load     = 1'b1;
                        load_idx = dir_q ? out_idx - IDX_ONE : out_idx + IDX_ONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            root_q  <= '0;
            out_idx <= '0;
            out_id  <= '0;
            out_tag <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                dir_q  <= dir;
                root_q <= root_id;
            end
            if (load) begin
                out_idx <= load_idx;
                out_id  <= load_root * ID_SCALE + ID_W'(load_idx);
                out_tag <= load_tag;
            end
        end
    end

endmodule

// File: tb/tb_inst_id_tree_scan.sv
// Randomised bench for inst_id_tree_scan: a leaf-tag array plus scan-order
// rules predict every record, the done pulse and reset behaviour.
module tb_inst_id_tree_scan;

    localparam int NLEAF    = 16;
    localparam int IDX_W    = 4;
    localparam int ID_W     = 32;
    localparam int TAG_W    = 8;
    localparam int TAG_BASE = 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic             dir;
    logic [ID_W-1:0]  root_id;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [TAG_W-1:0] wr_tag;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [ID_W-1:0]  out_id;
    logic [TAG_W-1:0] out_tag;
    logic             out_last;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [TAG_W-1:0] mdl_tag [NLEAF];

    inst_id_tree_scan #(
        .LEVELS  (4),
        .FANOUT  (2),
        .ID_W    (ID_W),
        .TAG_W   (TAG_W),
        .TAG_BASE(TAG_BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dir      (dir),
        .root_id  (root_id),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_tag   (wr_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx  (out_idx),
        .out_id   (out_id),
        .out_tag  (out_tag),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference leaf-tag array: reset defaults, writes land on the clock edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NLEAF; k++) mdl_tag[k] <= TAG_W'(TAG_BASE + k);
        end else if (wr_en && int'(wr_addr) < NLEAF) begin
            mdl_tag[wr_addr] <= wr_tag;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic write_tag(input logic [IDX_W-1:0] a, input logic [TAG_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_tag  = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // mode: 0 always ready, 1 five-cycle stall at record stall_at then toggle,
    // 2 random ready. rst_at/wr_at are record ordinals (-1 disables).
    task automatic run_scan(input bit d, input logic [ID_W-1:0] root, input int mode,
                            input int stall_at, input int rst_at, input int wr_at,
                            input logic [IDX_W-1:0] wr_a, input logic [TAG_W-1:0] wr_d,
                            input bit poke);
        int n;
        bit held;
        bit fin;
        bit stalled_once;
        bit phase;
        bit rdy;
        int stall_left;
        logic [IDX_W-1:0] e_idx;
        logic [ID_W-1:0]  e_id;
        logic [TAG_W-1:0] e_tag;
        n = 0; held = 0; fin = 0; stalled_once = 0; phase = 1; rdy = 1; stall_left = 0;
        e_idx = '0; e_id = '0; e_tag = '0;
        start = 1'b1; dir = d; root_id = root;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (n == NLEAF) begin
                check("done_pulse", done, 1);
                check("valid_after_last", out_valid, 0);
                check("busy_after_last", busy, 0);
                wr_en = 1'b0;
                start = poke; dir = ~d; root_id = $urandom;
                @(negedge clk);
                start = 1'b0;
                check("done_width", done, 0);
                check("start_in_done_ignored", out_valid, 0);
                fin = 1;
            end else begin
                check("valid", out_valid, 1);
                if (!out_valid) break;
                if (!held) begin
                    e_idx = d ? IDX_W'(NLEAF - 1 - n) : IDX_W'(n);
                    e_id  = root * ID_W'(NLEAF) + ID_W'(e_idx);
                    e_tag = mdl_tag[e_idx];
                end
                check("idx", out_idx, e_idx);
                check("id", out_id, e_id);
                check("tag", out_tag, e_tag);
                check("last", out_last, n == NLEAF - 1);
                check("busy", busy, 1);
                check("no_early_done", done, 0);
                if (n == rst_at) begin
                    rst = 1'b1; start = 1'b0; wr_en = 1'b0; out_ready = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    check("rst_valid", out_valid, 0);
                    check("rst_busy", busy, 0);
                    check("rst_done", done, 0);
                    check("rst_idx", out_idx, 0);
                    @(negedge clk);
                    check("rst_no_done", done, 0);
                    check("rst_idle", out_valid, 0);
                    return;
                end
                if (!held && n == stall_at) begin
                    stall_left   = 5;
                    stalled_once = 1;
                end
                if (mode == 2) begin
                    rdy = 1'($urandom_range(0, 1));
                end else if (stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else if (mode == 1 && stalled_once) begin
                    rdy   = phase;
                    phase = ~phase;
                end else begin
                    rdy = 1'b1;
                end
                out_ready = rdy;
                wr_en   = (!held && n == wr_at);
                wr_addr = wr_a;
                wr_tag  = wr_d;
                if (poke) begin
                    start   = 1'($urandom_range(0, 1));
                    dir     = ~d;
                    root_id = $urandom;
                end
                @(negedge clk);
                start = 1'b0;
                held  = !rdy;
                if (rdy) n++;
            end
        end
        check("scan_complete", n, NLEAF);
        out_ready = 1'b1;
        wr_en     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dir = 1'b0; root_id = '0;
        wr_en = 1'b0; wr_addr = '0; wr_tag = '0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_last", out_last, 0);
        check("reset_idx", out_idx, 0);
        check("reset_id", out_id, 0);
        check("reset_tag", out_tag, 0);

        run_scan(0, 32'd0, 0, -1, -1, -1, '0, '0, 0);
        run_scan(1, 32'd3, 0, -1, -1, -1, '0, '0, 0);
        run_scan(0, 32'd9, 1, 7, -1, -1, '0, '0, 0);

        write_tag(4'd5, 8'hAA);
        run_scan(0, 32'd0, 0, -1, -1, 4, 4'd2, 8'h55, 0);
        check("leaf2_written", mdl_tag[2], 8'h55);
        run_scan(0, 32'd0, 0, -1, -1, -1, '0, '0, 0);

        run_scan(0, 32'd7, 2, -1, -1, -1, '0, '0, 1);
        run_scan(0, 32'd1, 0, -1, 9, -1, '0, '0, 0);
        run_scan(0, 32'd0, 0, -1, -1, -1, '0, '0, 0);
        run_scan(0, 32'hFFFF_FFFF, 0, -1, -1, -1, '0, '0, 0);

        for (int r = 0; r < 6; r++) begin
            run_scan(1'($urandom_range(0, 1)), $urandom, 2, -1, -1,
                     $urandom_range(0, NLEAF - 1), IDX_W'($urandom_range(0, NLEAF - 1)),
                     TAG_W'($urandom), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
